// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

    localparam int unsigned MODE_STD  = 0;
    localparam int unsigned MODE_FWFT = 1;
    localparam int unsigned ERR_CNT_W = 16;

    // Pointer width: index bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read. Contents are not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with thresholds, occupancy, error pulses and standard/FWFT read modes.
// Optional saturating error counters (ovf_cnt/udf_cnt) exist only when SYNC_FIFO_ERR_CNT_EN is defined.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 4,
    parameter int unsigned AE_THRESH  = 2,
    parameter int unsigned FWFT       = MODE_STD,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    output logic                  underflow
`ifdef SYNC_FIFO_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]  ovf_cnt,
    output logic [ERR_CNT_W-1:0]  udf_cnt
`endif
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  ovf_q, udf_q;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    // Flags decode from registered pointers only, so they reflect the last edge.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= wr_en & full;
            udf_q    <= rd_en & empty;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (din),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    if (FWFT == MODE_FWFT) begin : g_fwft
        assign dout = rd_data;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rd_data;
            end
        end

        assign dout = dout_q;
    end

`ifdef SYNC_FIFO_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] ovf_cnt_q, udf_cnt_q;

    // Counters step on the same edge that raises the matching pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            if ((wr_en & full) && (ovf_cnt_q != '1)) begin
                ovf_cnt_q <= ovf_cnt_q + ERR_CNT_W'(1);
            end
            if ((rd_en & empty) && (udf_cnt_q != '1)) begin
                udf_cnt_q <= udf_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench: one standard-mode and one FWFT instance share stimulus; a queue model
// predicts occupancy, flags, pulses and read data, checked by a separate negedge monitor.
module tb_sync_fifo_flex;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;
    localparam int AW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wr_en, rd_en;
    logic [DW-1:0] din;

    logic [DW-1:0] dout_s, dout_f;
    logic          full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
    logic          full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [AW:0]   count_s, count_f;
`ifdef SYNC_FIFO_ERR_CNT_EN
    logic [15:0]   ovf_cnt_s, udf_cnt_s, ovf_cnt_f, udf_cnt_f;
`endif

    sync_fifo_flex #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_THRESH (AF), .AE_THRESH (AE), .FWFT (0)
    ) u_std (
        .clk (clk), .rst (rst), .wr_en (wr_en), .din (din), .rd_en (rd_en),
        .dout (dout_s), .full (full_s), .empty (empty_s), .almost_full (af_s),
        .almost_empty (ae_s), .count (count_s), .overflow (ovf_s), .underflow (udf_s)
`ifdef SYNC_FIFO_ERR_CNT_EN
        , .ovf_cnt (ovf_cnt_s), .udf_cnt (udf_cnt_s)
`endif
    );

    sync_fifo_flex #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_THRESH (AF), .AE_THRESH (AE), .FWFT (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .wr_en (wr_en), .din (din), .rd_en (rd_en),
        .dout (dout_f), .full (full_f), .empty (empty_f), .almost_full (af_f),
        .almost_empty (ae_f), .count (count_f), .overflow (ovf_f), .underflow (udf_f)
`ifdef SYNC_FIFO_ERR_CNT_EN
        , .ovf_cnt (ovf_cnt_f), .udf_cnt (udf_cnt_f)
`endif
    );

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_q[$];
    bit            exp_ovf, exp_udf;
    int            m_ovf_cnt, m_udf_cnt;
    bit            armed = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
        bit full_pre, empty_pre;
        if (r) begin
            q.delete();
            exp_q.delete();
            exp_q.push_back(8'h00);
            exp_ovf   = 1'b0;
            exp_udf   = 1'b0;
            m_ovf_cnt = 0;
            m_udf_cnt = 0;
        end else begin
            full_pre  = (q.size() == DEPTH);
            empty_pre = (q.size() == 0);
            exp_ovf   = w && full_pre;
            exp_udf   = rd && empty_pre;
            if (exp_ovf && m_ovf_cnt != 65535) m_ovf_cnt++;
            if (exp_udf && m_udf_cnt != 65535) m_udf_cnt++;
            if (rd && !empty_pre) exp_q.push_back(q.pop_front());
            if (w && !full_pre) q.push_back(d);
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
        rst   = r;
        wr_en = w;
        din   = d;
        rd_en = rd;
        @(posedge clk);
        model(r, w, d, rd);
        #1;
    endtask

    // Monitor: compares both DUTs against the model half a cycle after each edge.
    initial begin
        logic [DW-1:0] held;
        int            n;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (armed) begin
                n = q.size();
                chk("count",        32'(count_s), 32'(n));
                chk("full",         32'(full_s),  32'(n == DEPTH));
                chk("empty",        32'(empty_s), 32'(n == 0));
                chk("almost_full",  32'(af_s),    32'(n >= AF));
                chk("almost_empty", 32'(ae_s),    32'(n <= AE));
                chk("overflow",     32'(ovf_s),   32'(exp_ovf));
                chk("underflow",    32'(udf_s),   32'(exp_udf));
                chk("count_fwft",   32'(count_f), 32'(n));
                chk("empty_fwft",   32'(empty_f), 32'(n == 0));
                chk("ovf_fwft",     32'(ovf_f),   32'(exp_ovf));
                chk("udf_fwft",     32'(udf_f),   32'(exp_udf));
                if (n != 0) chk("dout_fwft", 32'(dout_f), 32'(q[0]));
                if (exp_q.size() > 0) held = exp_q.pop_front();
                chk("dout_std", 32'(dout_s), 32'(held));
`ifdef SYNC_FIFO_ERR_CNT_EN
                chk("ovf_cnt", 32'(ovf_cnt_s), 32'(m_ovf_cnt));
                chk("udf_cnt", 32'(udf_cnt_s), 32'(m_udf_cnt));
                chk("ovf_cnt_fwft", 32'(ovf_cnt_f), 32'(m_ovf_cnt));
`endif
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wp, rp;
        bit r, w, rd;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        armed = 1'b1;
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Fill past full: 16 accepted, 4 refused
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        chk("t1_count", 32'(count_s), 32'd16);
        chk("t1_full",  32'(full_s),  32'd1);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t2_count", 32'(count_s), 32'd11);
        chk("t2_af",    32'(af_s),    32'd0);
        chk("t2_dout",  32'(dout_s),  32'd4);

        for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t3_udf",   32'(udf_s),   32'd1);
        chk("t3_dout",  32'(dout_s),  32'd15);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("t3_udf_off", 32'(udf_s), 32'd0);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(100 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(200 + i), 1'b1);
        chk("t4_count", 32'(count_s), 32'd5);
        chk("t4_dout",  32'(dout_s),  32'd204);

        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("t5_empty_fwft", 32'(empty_f), 32'd0);
        chk("t5_dout_fwft",  32'(dout_f),  32'hA5);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t5_empty_after", 32'(empty_f), 32'd1);

        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(50 + i), 1'b0);
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        chk("t6_count", 32'(count_s), 32'd0);
        chk("t6_empty", 32'(empty_s), 32'd1);
        chk("t6_dout",  32'(dout_s),  32'd0);
`ifdef SYNC_FIFO_ERR_CNT_EN
        chk("t6_ovf_cnt", 32'(ovf_cnt_s), 32'd0);
`endif

        // Randomized traffic with varying write/read bias per block
        for (int blk = 0; blk < 30; blk++) begin
            wp = int'($urandom_range(10, 90));
            rp = int'($urandom_range(10, 90));
            for (int c = 0; c < 100; c++) begin
                r  = ($urandom_range(0, 299) == 0);
                w  = (int'($urandom_range(0, 99)) < wp);
                rd = (int'($urandom_range(0, 99)) < rp);
                step(r, w, 8'($urandom), rd);
            end
        end

        step(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
